// File: rtl/dll_sup_pkg.sv
// ---------------------------------------------------------------------------
// dll_sup_pkg
// Shared definitions for the DLL lock supervisor:
//   - sup_state_e : supervisor FSM state encoding
//   - DEF_*       : default values for the supervisor parameters
//   - cnt_width() : counter width able to hold 0 .. n-1 (never narrower than 1)
// ---------------------------------------------------------------------------
package dll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PULSE  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_FILTER = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } sup_state_e;

    localparam int DEF_RST_CYCLES   = 8;
    localparam int DEF_LOCK_FILTER  = 16;
    localparam int DEF_LOCK_TIMEOUT = 1 << 24;
    localparam int DEF_MAX_RETRY    = 7;

    // A counter that runs 0 .. n-1 needs clog2(n) bits. n of 1 would give
    // zero bits, so the result is clamped to one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dll_lock_supervisor_lock_sync.sv
// ---------------------------------------------------------------------------
// lock_sync
// Two-flop synchroniser that brings the DLL locked flag into the clkin
// domain. Output follows the input with two clkin cycles of latency.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset, clears both flops
//   d    - asynchronous input
//   q    - synchronised output
// ---------------------------------------------------------------------------
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // The first stage may go metastable; the second stage gives it a full
    // cycle to settle before anything downstream looks at it.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Both stages are cleared by reset so a stale lock from before reset
    // cannot leak into the supervisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// dll_lock_supervisor
// Brings a DLL out of reset, waits for a stable lock, reports ready, and
// retries with fresh reset pulses when lock is not achieved in time. After
// MAX_RETRY failed attempts it parks in FAULT until fault_clr.
// Ports:
//   clkin      - sole clock, rising edge
//   rst        - synchronous active-high reset
//   locked_raw - DLL locked flag, asynchronous to clkin
//   fault_clr  - single-cycle request to leave FAULT (ignored elsewhere)
//   dll_reset  - reset to the DLL primitive
//   ready      - clocks valid and stable
//   lock_lost  - one-cycle pulse when lock drops while running
//   retry_cnt  - failed lock attempts since last rst / fault_clr
//   fault      - retry budget exhausted
// ---------------------------------------------------------------------------
module dll_lock_supervisor
    import dll_sup_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic                           clkin,
    input  logic                           rst,
    input  logic                           locked_raw,
    input  logic                           fault_clr,
    output logic                           dll_reset,
    output logic                           ready,
    output logic                           lock_lost,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic                           fault
);

    localparam int PULSE_W = cnt_width(RST_CYCLES);
    localparam int FILT_W  = cnt_width(LOCK_FILTER);
    localparam int TO_W    = cnt_width(LOCK_TIMEOUT);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_CYCLES - 1);
    localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    sup_state_e         state_q,     state_d;
    logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [FILT_W-1:0]  filt_cnt_q,  filt_cnt_d;
    logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;
    logic [RETRY_W-1:0] retry_q,     retry_d;
    logic               dll_reset_q, dll_reset_d;
    logic               ready_q,     ready_d;
    logic               lock_lost_q, lock_lost_d;
    logic               fault_q,     fault_d;

    logic               locked_s;
    logic               timeout;
    logic [TO_W-1:0]    to_cnt_inc;
    logic [RETRY_W-1:0] retry_inc;

    lock_sync u_lock_sync (
        .clk (clkin),
        .rst (rst),
        .d   (locked_raw),
        .q   (locked_s)
    );

    // Next-state logic. The timeout counter only advances in WAIT and
    // FILTER and is cleared only when a new wait begins after a pulse, so a
    // bouncing lock cannot extend the window by hopping between WAIT and
    // FILTER. Outputs are computed from the next state so they are
    // registered together with the state.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        filt_cnt_d  = filt_cnt_q;
        to_cnt_d    = to_cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        timeout    = (to_cnt_q == TO_LAST);
        to_cnt_inc = timeout ? to_cnt_q : to_cnt_q + 1'b1;
        retry_inc  = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + 1'b1;

        case (state_q)
            ST_PULSE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d  = ST_WAIT;
                    to_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end

            ST_WAIT: begin
                to_cnt_d = to_cnt_inc;
                if (timeout) begin
                    retry_d     = retry_inc;
                    pulse_cnt_d = '0;
                    state_d     = (retry_inc >= RETRY_MAX) ? ST_FAULT : ST_PULSE;
                end else if (locked_s) begin
                    state_d    = ST_FILTER;
                    filt_cnt_d = '0;
                end
            end

            // A completed filter beats a simultaneous timeout: the DLL did
            // lock, so there is no reason to throw that away.
            ST_FILTER: begin
                to_cnt_d = to_cnt_inc;
                if (locked_s && (filt_cnt_q == FILT_LAST)) begin
                    state_d = ST_RUN;
                end else if (timeout) begin
                    retry_d     = retry_inc;
                    pulse_cnt_d = '0;
                    state_d     = (retry_inc >= RETRY_MAX) ? ST_FAULT : ST_PULSE;
                end else if (!locked_s) begin
                    state_d = ST_WAIT;
                end else begin
                    filt_cnt_d = filt_cnt_q + 1'b1;
                end
            end

            // Losing lock while running is not counted as a failed attempt.
            ST_RUN: begin
                if (!locked_s) begin
                    lock_lost_d = 1'b1;
                    pulse_cnt_d = '0;
                    state_d     = ST_PULSE;
                end
            end

            ST_FAULT: begin
                if (fault_clr) begin
                    retry_d     = '0;
                    pulse_cnt_d = '0;
                    state_d     = ST_PULSE;
                end
            end

            default: begin
                pulse_cnt_d = '0;
                state_d     = ST_PULSE;
            end
        endcase

        dll_reset_d = (state_d == ST_PULSE) || (state_d == ST_FAULT);
        ready_d     = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    // State and output registers. Reset lands in PULSE with the DLL held in
    // reset, so a full pulse follows every release of rst.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q     <= ST_PULSE;
            pulse_cnt_q <= '0;
            filt_cnt_q  <= '0;
            to_cnt_q    <= '0;
            retry_q     <= '0;
            dll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            to_cnt_q    <= to_cnt_d;
            retry_q     <= retry_d;
            dll_reset_q <= dll_reset_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            fault_q     <= fault_d;
        end
    end

    assign dll_reset = dll_reset_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_dll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_dll_lock_supervisor
// Directed bench for dll_lock_supervisor with RST_CYCLES=8, LOCK_FILTER=16,
// LOCK_TIMEOUT=100, MAX_RETRY=3. Inputs change and outputs are sampled 1ns
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_dll_lock_supervisor;

    logic       clkin;
    logic       rst;
    logic       locked_raw;
    logic       fault_clr;
    logic       dll_reset;
    logic       ready;
    logic       lock_lost;
    logic [1:0] retry_cnt;
    logic       fault;

    int checks;
    int errors;
    int n;
    int lost_seen;

    dll_lock_supervisor #(
        .RST_CYCLES   (8),
        .LOCK_FILTER  (16),
        .LOCK_TIMEOUT (100),
        .MAX_RETRY    (3)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .locked_raw (locked_raw),
        .fault_clr  (fault_clr),
        .dll_reset  (dll_reset),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt),
        .fault      (fault)
    );

    // 10ns clock
    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Every comparison goes through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive all inputs at once, away from the clock edge.
    task automatic applyStimulus(input logic r, input logic l, input logic c);
        rst        = r;
        locked_raw = l;
        fault_clr  = c;
    endtask

    task automatic tickN(input int cycles);
        repeat (cycles) begin
            @(posedge clkin);
            #1;
        end
    endtask

    // Counts cycles until dll_reset falls, starting from a sample where it
    // has just been raised; also counts any lock_lost pulses seen meanwhile.
    task automatic measurePulse(output int cycles, output int lost);
        cycles = 0;
        lost   = 0;
        while (dll_reset === 1'b1 && cycles < 64) begin
            tickN(1);
            cycles++;
            if (lock_lost === 1'b1) lost++;
        end
    endtask

    task automatic cyclesUntilReady(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 300) begin
            tickN(1);
            cycles++;
        end
    endtask

    task automatic cyclesUntilRetry(input logic [1:0] target, output int cycles);
        cycles = 0;
        while (retry_cnt !== target && cycles < 300) begin
            tickN(1);
            cycles++;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_dll_reset"}, 32'(dll_reset), 32'd1);
        checkOutput({tag, "_ready"},     32'(ready),     32'd0);
        checkOutput({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
        checkOutput({tag, "_fault"},     32'(fault),     32'd0);
        checkOutput({tag, "_retry"},     32'(retry_cnt), 32'd0);
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        checks = 0;
        errors = 0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickN(3);
        checkResetOutputs("reset");

        // Power-up: 8-cycle pulse, then lock 20 cycles after rst release
        applyStimulus(1'b0, 1'b0, 1'b0);
        measurePulse(n, lost_seen);
        checkOutput("powerup_pulse_len", 32'(n), 32'd8);
        tickN(12);
        checkOutput("wait_ready_low", 32'(ready), 32'd0);
        checkOutput("wait_dll_reset_low", 32'(dll_reset), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        cyclesUntilReady(n);
        checkOutput("lock_to_ready", 32'(n), 32'd19);
        checkOutput("run_retry", 32'(retry_cnt), 32'd0);

        // fault_clr while running is ignored
        applyStimulus(1'b0, 1'b1, 1'b1);
        tickN(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tickN(2);
        checkOutput("clr_in_run_ready", 32'(ready), 32'd1);
        checkOutput("clr_in_run_dll_reset", 32'(dll_reset), 32'd0);
        checkOutput("clr_in_run_fault", 32'(fault), 32'd0);

        // One-cycle lock glitch while running
        applyStimulus(1'b0, 1'b0, 1'b0);
        tickN(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tickN(1);
        checkOutput("glitch_lost_early", 32'(lock_lost), 32'd0);
        checkOutput("glitch_ready_early", 32'(ready), 32'd1);
        tickN(1);
        checkOutput("glitch_lost_pulse", 32'(lock_lost), 32'd1);
        checkOutput("glitch_ready_drop", 32'(ready), 32'd0);
        checkOutput("glitch_dll_reset", 32'(dll_reset), 32'd1);
        measurePulse(n, lost_seen);
        checkOutput("glitch_pulse_len", 32'(n), 32'd8);
        checkOutput("glitch_lost_extra", 32'(lost_seen), 32'd0);
        checkOutput("glitch_retry", 32'(retry_cnt), 32'd0);
        cyclesUntilReady(n);
        checkOutput("glitch_relock", 32'(n), 32'd17);

        // Lock drop during FILTER at filter count 10
        applyStimulus(1'b0, 1'b0, 1'b0);
        tickN(3);
        checkOutput("drop_dll_reset", 32'(dll_reset), 32'd1);
        measurePulse(n, lost_seen);
        checkOutput("drop_pulse_len", 32'(n), 32'd8);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tickN(11);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tickN(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        cyclesUntilReady(n);
        checkOutput("filter_restart", 32'(n), 32'd19);
        checkOutput("filter_retry", 32'(retry_cnt), 32'd0);

        // rst for one cycle while running
        applyStimulus(1'b1, 1'b1, 1'b0);
        tickN(1);
        checkResetOutputs("rst_in_run");
        applyStimulus(1'b0, 1'b1, 1'b0);
        measurePulse(n, lost_seen);
        checkOutput("rst_run_pulse_len", 32'(n), 32'd8);
        cyclesUntilReady(n);
        checkOutput("rst_run_relock", 32'(n), 32'd17);

        // No lock at all: three timeouts then FAULT
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickN(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        measurePulse(n, lost_seen);
        checkOutput("to_first_pulse", 32'(n), 32'd8);
        for (int k = 1; k <= 3; k++) begin
            cyclesUntilRetry(2'(k), n);
            checkOutput($sformatf("timeout%0d_cycles", k), 32'(n), 32'd100);
            if (k < 3) begin
                measurePulse(n, lost_seen);
                checkOutput($sformatf("timeout%0d_pulse", k), 32'(n), 32'd8);
            end
        end
        checkOutput("fault_set", 32'(fault), 32'd1);
        checkOutput("fault_dll_reset", 32'(dll_reset), 32'd1);
        checkOutput("fault_ready", 32'(ready), 32'd0);
        tickN(20);
        checkOutput("fault_hold", 32'(fault), 32'd1);
        checkOutput("fault_hold_retry", 32'(retry_cnt), 32'd3);
        checkOutput("fault_hold_dll_reset", 32'(dll_reset), 32'd1);

        // Leave FAULT with fault_clr and a good lock
        applyStimulus(1'b0, 1'b1, 1'b0);
        tickN(4);
        checkOutput("fault_needs_clr", 32'(fault), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tickN(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clr_retry", 32'(retry_cnt), 32'd0);
        checkOutput("clr_fault", 32'(fault), 32'd0);
        checkOutput("clr_dll_reset", 32'(dll_reset), 32'd1);
        measurePulse(n, lost_seen);
        checkOutput("clr_pulse_len", 32'(n), 32'd8);
        cyclesUntilReady(n);
        checkOutput("clr_relock", 32'(n), 32'd17);

        // Back into FAULT, then rst together with fault_clr
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickN(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tickN(324);
        checkOutput("refault", 32'(fault), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tickN(1);
        checkResetOutputs("rst_in_fault");
        applyStimulus(1'b0, 1'b0, 1'b0);
        measurePulse(n, lost_seen);
        checkOutput("rst_fault_pulse_len", 32'(n), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dll_lock_supervisor.md
DLL_LOCK_SUPERVISOR -- requirements
Module: dll_lock_supervisor

Interface
REQ-001 Parameter RST_CYCLES, default 8: length of each DLL reset pulse in clkin cycles, minimum 1.
REQ-002 Parameter LOCK_FILTER, default 16: consecutive synchronised-lock cycles required before ready, minimum 1.
REQ-003 Parameter LOCK_TIMEOUT, default 2^24: cycles allowed from end of reset pulse to a filtered lock.
REQ-004 Parameter MAX_RETRY, default 7: failed lock attempts tolerated before fault, minimum 1.
REQ-005 Port clkin, input, 1: sole clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset; synchronous and active-high.
REQ-007 Port locked_raw, input, 1: DLL locked flag; asynchronous to clkin.
REQ-008 Port fault_clr, input, 1: single-cycle request to leave FAULT.
REQ-009 Port dll_reset, output, 1: reset to the DLL primitive.
REQ-010 Port ready, output, 1: clocks are valid and stable.
REQ-011 Port lock_lost, output, 1: one-cycle pulse when lock drops while in RUN.
REQ-012 Port retry_cnt, output, clog2(MAX_RETRY+1): failed attempts since the last fault_clr or rst.
REQ-013 Port fault, output, 1: retry budget exhausted.

Function
REQ-014 locked_raw SHALL pass a 2-flop synchroniser to form locked_s, with 2 cycles latency.
REQ-015 FSM states SHALL be PULSE, WAIT, FILTER, RUN and FAULT; all outputs are registered.
REQ-016 PULSE: dll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT, with the timeout counter cleared.
REQ-017 WAIT: dll_reset=0; if locked_s=1, go to FILTER with the filter counter cleared.
REQ-018 FILTER: the filter counter SHALL increment each cycle locked_s=1.
REQ-019 FILTER: when the filter counter reaches LOCK_FILTER-1 with locked_s=1, go to RUN.
REQ-020 FILTER: if locked_s=0, return to WAIT; this is not a retry, and the timeout counter is not cleared.
REQ-021 The timeout counter SHALL run in WAIT and FILTER, saturate, and trigger a timeout when it equals LOCK_TIMEOUT-1.
REQ-022 On timeout, retry_cnt SHALL increment; if the new value equals MAX_RETRY go to FAULT, else go to PULSE.
REQ-023 RUN: ready=1; if locked_s=0, assert lock_lost for one cycle, deassert ready in the same cycle, and go to PULSE; retry_cnt is unchanged.
REQ-024 FAULT: dll_reset=1, fault=1 and ready=0 are held; fault_clr=1 SHALL clear retry_cnt and go to PULSE.
REQ-025 fault_clr outside FAULT SHALL be ignored.
REQ-026 If timeout and the FILTER-completion condition coincide, completion (RUN) SHALL win.
REQ-027 The RUN-state test on locked_s=0 takes priority over all other RUN behaviour.
REQ-028 retry_cnt SHALL never exceed MAX_RETRY.

Reset
REQ-029 rst=1 SHALL force PULSE with the pulse counter cleared.
REQ-030 rst=1 SHALL set dll_reset=1, ready=0, lock_lost=0, fault=0 and retry_cnt=0.
REQ-031 rst=1 SHALL clear the synchroniser flops, the filter counter and the timeout counter.
REQ-032 rst asserted mid-operation, including in FAULT or RUN, SHALL take effect on the next edge and override fault_clr.
REQ-033 After rst falls, dll_reset SHALL stay high for exactly RST_CYCLES cycles.

Structure
REQ-034 Package dll_sup_pkg SHALL hold the state enum, the parameter defaults and a clog2-based width function.
REQ-035 Sub-module lock_sync SHALL implement the parameterless 2-flop synchroniser; everything else stays in dll_lock_supervisor.
REQ-036 Each counter width SHALL be derived from its own parameter.

Verification
(All scenarios use RST_CYCLES=8, LOCK_FILTER=16, LOCK_TIMEOUT=100, MAX_RETRY=3.)
REQ-037 Release rst, then raise locked_raw 20 cycles later: dll_reset high 8 cycles, and ready rises 2+16 cycles after locked_raw plus FSM registration; retry_cnt=0.
REQ-038 locked_raw held 0: three timeouts occur 100 cycles apart, separated by 8-cycle pulses; fault=1 when retry_cnt=3; dll_reset held high.
REQ-039 In FAULT, pulse fault_clr: retry_cnt=0, then an 8-cycle pulse; with locked_raw=1, ready follows; fault_clr given in RUN has no effect.
REQ-040 In RUN, drop locked_raw for 1 cycle: exactly one lock_lost pulse, ready falls, an 8-cycle dll_reset pulse follows, and retry_cnt is unchanged.
REQ-041 In FILTER, toggle locked_raw low at filter count 10: return to WAIT, the filter restarts, no retry increments, and ready comes only after a further 16 clean cycles.
REQ-042 Assert rst for 1 cycle while in RUN and again while in FAULT: all outputs return to their reset values on the next edge.
